// File: rtl/btn_pkg.sv
// Shared types and width helpers for the debounced push-button reader.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RPT  = 2'd2
  } hold_state_t;

  localparam int DEF_DEBOUNCE = 2000000;
  localparam int DEF_HOLD     = 50000000;
  localparam int DEF_REPEAT   = 10000000;

  function automatic int dbWidth(input int debounce);
    return $clog2(debounce);
  endfunction

  // One counter serves both the initial hold and the repeat interval.
  function automatic int holdWidth(input int hold, input int rpt);
    return ($clog2(hold) > $clog2(rpt)) ? $clog2(hold) : $clog2(rpt);
  endfunction

  localparam int DEF_DB_W   = dbWidth(DEF_DEBOUNCE);
  localparam int DEF_HOLD_W = holdWidth(DEF_HOLD, DEF_REPEAT);

endpackage

// File: rtl/btn_channel.sv
// One button: two-flop synchronizer, counting debouncer and hold-to-repeat FSM.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE = DEF_DEBOUNCE,
  parameter int HOLD     = DEF_HOLD,
  parameter int REPEAT   = DEF_REPEAT
) (
  input  logic clk,
  input  logic rst,
  input  logic btnIn,
  output logic level,
  output logic press,
  output logic releasePulse,
  output logic repeatPulse
);

  localparam int DB_W   = dbWidth(DEBOUNCE);
  localparam int HOLD_W = holdWidth(HOLD, REPEAT);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
  localparam logic [HOLD_W-1:0] RPT_LAST  = HOLD_W'(REPEAT - 1);

  logic              sync0;
  logic              sync1;
  logic [DB_W-1:0]   dbCnt;
  logic              accept;
  logic              rise;
  logic              fall;
  hold_state_t       state;
  hold_state_t       stateNext;
  logic [HOLD_W-1:0] holdCnt;
  logic [HOLD_W-1:0] holdCntNext;
  logic              repeatNext;

  assign accept = (sync1 != level) && (dbCnt == DB_LAST);
  assign rise   = accept && sync1;
  assign fall   = accept && !sync1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= btnIn;
      sync1 <= sync0;
    end
  end

  // Any cycle where the synchronized input agrees with level restarts the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dbCnt        <= '0;
      level        <= 1'b0;
      press        <= 1'b0;
      releasePulse <= 1'b0;
    end else begin
      press        <= rise;
      releasePulse <= fall;
      if (sync1 == level) begin
        dbCnt <= '0;
      end else if (accept) begin
        dbCnt <= '0;
        level <= sync1;
      end else begin
        dbCnt <= dbCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      holdCnt     <= '0;
      repeatPulse <= 1'b0;
    end else begin
      state       <= stateNext;
      holdCnt     <= holdCntNext;
      repeatPulse <= repeatNext;
    end
  end

  // The FSM reacts to the acceptance itself so WAIT starts on the press edge.
  always_comb begin
    stateNext   = state;
    holdCntNext = holdCnt;
    repeatNext  = 1'b0;
    if (fall) begin
      stateNext   = IDLE;
      holdCntNext = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            stateNext   = WAIT;
            holdCntNext = '0;
          end
        end
        WAIT: begin
          if (holdCnt == HOLD_LAST) begin
            repeatNext  = 1'b1;
            holdCntNext = '0;
            stateNext   = RPT;
          end else begin
            holdCntNext = holdCnt + 1'b1;
          end
        end
        RPT: begin
          if (holdCnt == RPT_LAST) begin
            repeatNext  = 1'b1;
            holdCntNext = '0;
          end else begin
            holdCntNext = holdCnt + 1'b1;
          end
        end
        default: begin
          stateNext   = IDLE;
          holdCntNext = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_reader.sv
// Debounced push-button reader: NUM_BTN independent channels of level, press,
// release and hold-to-repeat pulses.
module btn_reader
  import btn_pkg::*;
#(
  parameter int NUM_BTN  = 4,
  parameter int DEBOUNCE = DEF_DEBOUNCE,
  parameter int HOLD     = DEF_HOLD,
  parameter int REPEAT   = DEF_REPEAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btnIn,
  output logic [NUM_BTN-1:0] level,
  output logic [NUM_BTN-1:0] press,
  output logic [NUM_BTN-1:0] releasePulse,
  output logic [NUM_BTN-1:0] repeatPulse
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : gChan
    btn_channel #(
      .DEBOUNCE(DEBOUNCE),
      .HOLD    (HOLD),
      .REPEAT  (REPEAT)
    ) uChannel (
      .clk         (clk),
      .rst         (rst),
      .btnIn       (btnIn[i]),
      .level       (level[i]),
      .press       (press[i]),
      .releasePulse(releasePulse[i]),
      .repeatPulse (repeatPulse[i])
    );
  end

endmodule

// File: tb/tb_btn_reader.sv
// Scoreboard bench for btn_reader with DEBOUNCE=4, HOLD=10, REPEAT=3.
module tb_btn_reader;

  localparam int KIND_PRESS = 0;
  localparam int KIND_REL   = 1;
  localparam int KIND_RPT   = 2;

  typedef struct {
    int         cyc;
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] rp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btnIn;
  logic [3:0] level;
  logic [3:0] press;
  logic [3:0] releasePulse;
  logic [3:0] repeatPulse;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];

  btn_reader #(
    .NUM_BTN (4),
    .DEBOUNCE(4),
    .HOLD    (10),
    .REPEAT  (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btnIn       (btnIn),
    .level       (level),
    .press       (press),
    .releasePulse(releasePulse),
    .repeatPulse (repeatPulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected pulses are kept sorted by cycle; same-cycle events merge.
  function automatic void pushExp(input int c, input int ch, input int kind);
    exp_t e;
    int   idx;
    idx = expQ.size();
    for (int i = 0; i < expQ.size(); i++) begin
      if (expQ[i].cyc >= c) begin
        idx = i;
        break;
      end
    end
    if (idx < expQ.size() && expQ[idx].cyc == c) begin
      e = expQ[idx];
    end else begin
      e.cyc = c;
      e.pr  = '0;
      e.rl  = '0;
      e.rp  = '0;
      expQ.insert(idx, e);
    end
    if (kind == KIND_PRESS) e.pr[ch] = 1'b1;
    else if (kind == KIND_REL) e.rl[ch] = 1'b1;
    else e.rp[ch] = 1'b1;
    expQ[idx] = e;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] val);
    btnIn = val;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, req);
    end
  endtask

  // Monitor: any pulse on the outputs must match the head of the scoreboard.
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL missed_pulse at cycle %0d: got none, expected pr=%b rl=%b rp=%b",
               expQ[0].cyc, expQ[0].pr, expQ[0].rl, expQ[0].rp);
      void'(expQ.pop_front());
    end
    if (|{press, releasePulse, repeatPulse}) begin
      checks++;
      if (expQ.size() == 0 || expQ[0].cyc != cyc) begin
        errors++;
        $display("[TB] FAIL unexpected_pulse at cycle %0d: got pr=%b rl=%b rp=%b, expected none",
                 cyc, press, releasePulse, repeatPulse);
      end else begin
        if ({press, releasePulse, repeatPulse} !== {expQ[0].pr, expQ[0].rl, expQ[0].rp}) begin
          errors++;
          $display("[TB] FAIL pulse_value at cycle %0d: got pr=%b rl=%b rp=%b, expected pr=%b rl=%b rp=%b",
                   cyc, press, releasePulse, repeatPulse, expQ[0].pr, expQ[0].rl, expQ[0].rp);
        end
        void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e;
    rst   = 1'b0;
    btnIn = 4'b0000;

    // Reset then idle
    step(3);
    checkOutput("rst_level", level, 4'b0000);
    checkOutput("rst_press", press, 4'b0000);
    checkOutput("rst_release", releasePulse, 4'b0000);
    checkOutput("rst_repeat", repeatPulse, 4'b0000);
    rst = 1'b1;
    step(10);
    checkOutput("idle_level", level, 4'b0000);

    // Clean press and release on channel 0
    $display("[TB] clean press");
    e = cyc;
    applyStimulus(4'b0001);
    pushExp(e + 6, 0, KIND_PRESS);
    pushExp(e + 14, 0, KIND_REL);
    step(5);
    checkOutput("press_level_early", level, 4'b0000);
    step(1);
    checkOutput("press_level", level, 4'b0001);
    step(2);
    applyStimulus(4'b0000);
    step(6);
    checkOutput("release_level", level, 4'b0000);
    step(6);

    // Bounce rejection on channel 1
    $display("[TB] bounce rejection");
    applyStimulus(4'b0010);
    step(1);
    applyStimulus(4'b0000);
    step(1);
    applyStimulus(4'b0010);
    step(1);
    applyStimulus(4'b0000);
    step(6);
    applyStimulus(4'b0010);
    step(3);
    applyStimulus(4'b0000);
    step(8);
    checkOutput("bounce_level", level, 4'b0000);

    // Hold repeat on channel 2, release lands where a repeat would fall
    $display("[TB] hold repeat");
    e = cyc;
    applyStimulus(4'b0100);
    pushExp(e + 6, 2, KIND_PRESS);
    for (int k = 0; k < 9; k++) pushExp(e + 16 + 3 * k, 2, KIND_RPT);
    pushExp(e + 43, 2, KIND_REL);
    step(6);
    checkOutput("hold_level", level, 4'b0100);
    step(31);
    applyStimulus(4'b0000);
    step(6);
    checkOutput("hold_release_level", level, 4'b0000);
    step(8);

    // Simultaneous presses on channels 0 and 3
    $display("[TB] simultaneous");
    e = cyc;
    applyStimulus(4'b1001);
    pushExp(e + 6, 0, KIND_PRESS);
    pushExp(e + 6, 3, KIND_PRESS);
    for (int k = 0; k < 7; k++) pushExp(e + 16 + 3 * k, 0, KIND_RPT);
    for (int k = 0; k < 4; k++) pushExp(e + 16 + 3 * k, 3, KIND_RPT);
    pushExp(e + 26, 3, KIND_REL);
    pushExp(e + 36, 0, KIND_REL);
    step(6);
    checkOutput("simul_level", level, 4'b1001);
    step(14);
    applyStimulus(4'b0001);
    step(6);
    checkOutput("simul_ch3_rel_level", level, 4'b0001);
    step(4);
    applyStimulus(4'b0000);
    step(6);
    checkOutput("simul_end_level", level, 4'b0000);
    step(6);

    // Reset while channel 2 is repeating
    $display("[TB] reset mid-hold");
    e = cyc;
    applyStimulus(4'b0100);
    pushExp(e + 6, 2, KIND_PRESS);
    pushExp(e + 16, 2, KIND_RPT);
    pushExp(e + 19, 2, KIND_RPT);
    step(20);
    rst = 1'b0;
    step(1);
    checkOutput("midrst_level", level, 4'b0000);
    checkOutput("midrst_press", press, 4'b0000);
    checkOutput("midrst_release", releasePulse, 4'b0000);
    checkOutput("midrst_repeat", repeatPulse, 4'b0000);
    step(1);
    rst = 1'b1;
    pushExp(e + 28, 2, KIND_PRESS);
    step(5);
    checkOutput("repress_level_early", level, 4'b0000);
    step(1);
    checkOutput("repress_level", level, 4'b0100);
    step(2);
    applyStimulus(4'b0000);
    pushExp(e + 36, 2, KIND_REL);
    step(12);

    while (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL leftover_pulse: got none, expected cycle %0d pr=%b rl=%b rp=%b",
               expQ[0].cyc, expQ[0].pr, expQ[0].rl, expQ[0].rp);
      void'(expQ.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
